// File: rtl/lii_tx_arbiter.sv
// Round-robin arbiter sharing one LII phy transmit channel between N_REQ streams.
// Grants are bounded to MAX_BURST beats; one registered output stage forwards data/src/dst.
module lii_tx_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned PW        = 64,
  parameter int unsigned MAX_BURST = 4,
  localparam int unsigned GW       = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               aclk,
  input  logic               arst,
  input  logic [N_REQ*PW-1:0] lii_req_tdata,
  input  logic [N_REQ-1:0]   lii_req_tvalid,
  output logic [N_REQ-1:0]   lii_req_tready,
  input  logic [N_REQ*8-1:0] lii_req_src,
  input  logic [N_REQ*8-1:0] lii_req_dst,
  output logic [PW-1:0]      lii_out_p0_tdata,
  output logic               lii_out_p0_tvalid,
  input  logic               lii_out_p0_tready,
  output logic [7:0]         lii_out_p0_src,
  output logic [7:0]         lii_out_p0_dst,
  output logic [GW-1:0]      grant_id,
  output logic               busy
);

  localparam int unsigned BW = $clog2(MAX_BURST + 1);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_GRANT = 1'b1;

  logic [0:0]    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] rr_q, rr_d;
  logic [BW-1:0] beat_q, beat_d;

  logic          out_full_q;
  logic [PW-1:0] out_data_q;
  logic [7:0]    out_src_q;
  logic [7:0]    out_dst_q;

  logic          load_ok;
  logic          xfer;
  logic [GW-1:0] pick;
  logic          pick_vld;

  logic [PW-1:0] req_data [N_REQ];
  logic [7:0]    req_src  [N_REQ];
  logic [7:0]    req_dst  [N_REQ];

  // Unpacked views of the packed requester buses
  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign req_data[i] = lii_req_tdata[i*PW +: PW];
    assign req_src[i]  = lii_req_src[i*8 +: 8];
    assign req_dst[i]  = lii_req_dst[i*8 +: 8];
  end

  assign load_ok = ~out_full_q | lii_out_p0_tready;

  // First valid requester searching from rr_q upward, wrapping at N_REQ
  always_comb begin
    logic [GW-1:0] idx;
    idx      = rr_q;
    pick     = '0;
    pick_vld = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (!pick_vld && lii_req_tvalid[idx]) begin
        pick     = idx;
        pick_vld = 1'b1;
      end
      idx = (idx == GW'(N_REQ - 1)) ? '0 : idx + GW'(1);
    end
  end

  // Next-state and ready generation; backpressure never releases a grant
  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    rr_d           = rr_q;
    beat_d         = beat_q;
    lii_req_tready = '0;
    xfer           = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (pick_vld) begin
          grant_d = pick;
          beat_d  = '0;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        lii_req_tready[grant_q] = load_ok;
        xfer = lii_req_tvalid[grant_q] & load_ok;
        if (xfer) begin
          beat_d = beat_q + BW'(1);
        end
        if (!lii_req_tvalid[grant_q] || (xfer && (beat_q == BW'(MAX_BURST - 1)))) begin
          state_d = ST_IDLE;
          beat_d  = '0;
          rr_d    = (grant_q == GW'(N_REQ - 1)) ? '0 : grant_q + GW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk) begin
    if (arst) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      beat_q  <= beat_d;
    end
  end

  // Output register: a simultaneous drain and load keeps it full with the new beat
  always_ff @(posedge aclk) begin
    if (arst) begin
      out_full_q <= 1'b0;
      out_data_q <= '0;
      out_src_q  <= '0;
      out_dst_q  <= '0;
    end else if (xfer) begin
      out_full_q <= 1'b1;
      out_data_q <= req_data[grant_q];
      out_src_q  <= req_src[grant_q];
      out_dst_q  <= req_dst[grant_q];
    end else if (lii_out_p0_tready) begin
      out_full_q <= 1'b0;
    end
  end

  assign lii_out_p0_tvalid = out_full_q;
  assign lii_out_p0_tdata  = out_data_q;
  assign lii_out_p0_src    = out_src_q;
  assign lii_out_p0_dst    = out_dst_q;
  assign grant_id          = grant_q;
  assign busy              = (state_q == ST_GRANT) | out_full_q;

endmodule

// File: tb/tb_lii_tx_arbiter.sv
// Scoreboard bench for lii_tx_arbiter: requester drivers log accepted beats,
// an output monitor matches emitted beats per source and against expected grant order.
module tb_lii_tx_arbiter;

  localparam int N  = 4;
  localparam int PW = 64;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            arst;
  logic [N*PW-1:0] req_tdata;
  logic [N-1:0]    req_tvalid;
  logic [N-1:0]    req_tready;
  logic [N*8-1:0]  req_src;
  logic [N*8-1:0]  req_dst;
  logic [PW-1:0]   out_tdata;
  logic            out_tvalid;
  logic            out_tready;
  logic [7:0]      out_src;
  logic [7:0]      out_dst;
  logic [1:0]      grant_id;
  logic            busy;

  lii_tx_arbiter #(.N_REQ(N), .PW(PW), .MAX_BURST(MB)) dut (
    .aclk              (clk),
    .arst              (arst),
    .lii_req_tdata     (req_tdata),
    .lii_req_tvalid    (req_tvalid),
    .lii_req_tready    (req_tready),
    .lii_req_src       (req_src),
    .lii_req_dst       (req_dst),
    .lii_out_p0_tdata  (out_tdata),
    .lii_out_p0_tvalid (out_tvalid),
    .lii_out_p0_tready (out_tready),
    .lii_out_p0_src    (out_src),
    .lii_out_p0_dst    (out_dst),
    .grant_id          (grant_id),
    .busy              (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          r;
    logic [63:0] d;
    logic [7:0]  dst;
  } beat_t;

  beat_t exp_q[$];
  int    ord_q[$];
  int    in_cyc_q[$];
  int    out_cyc_q[$];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int out_beats = 0;

  bit          en[N];
  bit          seq[N];
  int          cnt_left[N];
  int          rate[N];
  int          hs_cnt[N];
  bit          pend[N];
  logic [63:0] seq_nxt[N];
  int          abort_pct = 0;
  bit          tr_mode = 1'b0;
  bit          tr_val = 1'b1;
  bit          lat_chk = 1'b0;
  bit          gap_chk = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Requester drivers and out tready: log handshakes at negedge, update after posedge
  initial begin
    req_tvalid = '0;
    req_tdata  = '0;
    req_dst    = '0;
    out_tready = 1'b1;
    for (int i = 0; i < N; i++) req_src[i*8 +: 8] = 8'(i);
    forever begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        pend[i] = req_tvalid[i] && req_tready[i] && !arst;
        if (pend[i]) begin
          beat_t b;
          b.r   = i;
          b.d   = req_tdata[i*PW +: PW];
          b.dst = req_dst[i*8 +: 8];
          exp_q.push_back(b);
          hs_cnt[i]++;
          if (cnt_left[i] > 0) cnt_left[i]--;
          if (lat_chk) in_cyc_q.push_back(cyc);
        end
      end
      @(posedge clk);
      #2;
      out_tready = tr_mode ? ($urandom_range(0, 99) < 70) : tr_val;
      for (int i = 0; i < N; i++) begin
        if (!en[i]) begin
          req_tvalid[i] = 1'b0;
        end else if (req_tvalid[i] && !pend[i]) begin
          if ($urandom_range(0, 99) < abort_pct) req_tvalid[i] = 1'b0;
        end else if (cnt_left[i] > 0 && $urandom_range(0, 99) < rate[i]) begin
          req_tvalid[i] = 1'b1;
          if (seq[i]) begin
            req_tdata[i*PW +: PW] = seq_nxt[i];
            seq_nxt[i]++;
            req_dst[i*8 +: 8] = 8'h07;
          end else begin
            req_tdata[i*PW +: PW] = {$urandom, $urandom};
            req_dst[i*8 +: 8]     = 8'($urandom);
          end
        end else begin
          req_tvalid[i] = 1'b0;
        end
      end
    end
  end

  // Output monitor: per-source ordering, optional grant order and latency checks
  initial begin
    forever begin
      @(negedge clk);
      if (!arst && out_tvalid && out_tready) begin
        int idx;
        idx = -1;
        out_beats++;
        if (gap_chk) out_cyc_q.push_back(cyc);
        if (lat_chk) begin
          if (in_cyc_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL latency: output beat with no accepted input (cycle %0d)", cyc);
          end else begin
            chk("latency", 64'(cyc), 64'(in_cyc_q.pop_front() + 1));
          end
        end
        if (ord_q.size() > 0) chk("grant_order", 64'(out_src), 64'(ord_q.pop_front()));
        for (int j = 0; j < exp_q.size(); j++)
          if (idx < 0 && exp_q[j].r == int'(out_src)) idx = j;
        if (idx < 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: src 0x%0h data 0x%0h not pending (cycle %0d)", out_src, out_tdata, cyc);
        end else begin
          chk("data", out_tdata, exp_q[idx].d);
          chk("dst", 64'(out_dst), 64'(exp_q[idx].dst));
          exp_q.delete(idx);
        end
      end
    end
  end

  function automatic bit all_idle();
    bit r;
    r = (req_tvalid == '0) && !out_tvalid && (exp_q.size() == 0);
    for (int i = 0; i < N; i++) if (cnt_left[i] != 0) r = 1'b0;
    return r;
  endfunction

  task automatic drain(input string name, input int maxc);
    int c;
    c = 0;
    while (c < maxc && !all_idle()) begin
      @(posedge clk);
      #3;
      c++;
    end
    n_tests++;
    if (c >= maxc) begin
      n_fail++;
      $display("FAIL %s_drain: timeout, %0d beats still pending", name, exp_q.size());
    end
  endtask

  task automatic chk_gaps(input string name);
    for (int k = 0; k + 1 < out_cyc_q.size(); k++)
      chk(name, 64'(out_cyc_q[k+1] - out_cyc_q[k]), ((k + 1) % MB == 0) ? 64'd2 : 64'd1);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    ord_q.delete();
    in_cyc_q.delete();
    out_cyc_q.delete();
    out_beats = 0;
  endtask

  task automatic do_reset();
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b0; seq[i] = 1'b0; cnt_left[i] = 0; rate[i] = 100; hs_cnt[i] = 0;
    end
    abort_pct = 0; tr_mode = 1'b0; tr_val = 1'b1; lat_chk = 1'b0; gap_chk = 1'b0;
    @(posedge clk);
    #1 arst = 1'b1;
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
    clear_sb();
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int c;
    // Reset with every requester presenting a beat
    arst = 1'b1;
    for (int i = 0; i < N; i++) begin
      en[i] = 1'b1; seq[i] = 1'b0; cnt_left[i] = 1; rate[i] = 100; hs_cnt[i] = 0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 64'(out_tvalid), 64'd0);
    chk("rst_tready", 64'(req_tready), 64'd0);
    chk("rst_grant", 64'(grant_id), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_tdata", out_tdata, 64'd0);
    do_reset();

    // Single requester: req2 streams 0x10..0x1B, dst 0x07
    seq[2] = 1'b1; seq_nxt[2] = 64'h10; cnt_left[2] = 12; lat_chk = 1'b1; gap_chk = 1'b1; en[2] = 1'b1;
    drain("single", 300);
    chk("single_count", 64'(out_cyc_q.size()), 64'd12);
    chk_gaps("single_gap");

    // Fairness: all requesters continuously valid
    do_reset();
    for (int k = 0; k < 8 * N; k++) ord_q.push_back((k / MB) % N);
    lat_chk = 1'b1; gap_chk = 1'b1;
    for (int i = 0; i < N; i++) begin cnt_left[i] = 8; en[i] = 1'b1; end
    drain("fair", 500);
    chk("fair_order_left", 64'(ord_q.size()), 64'd0);
    chk("fair_count", 64'(out_cyc_q.size()), 64'(8 * N));
    chk_gaps("fair_gap");

    // Backpressure on req0's second beat for 5 cycles
    do_reset();
    seq[0] = 1'b1; seq_nxt[0] = 64'h100; cnt_left[0] = 8; en[0] = 1'b1;
    c = 0;
    while (out_beats < 1 && c < 50) begin @(posedge clk); #1; c++; end
    chk("bp_first_beat", 64'(out_beats), 64'd1);
    tr_val = 1'b0;
    for (int h = 0; h < 5; h++) begin
      @(negedge clk);
      chk("bp_tvalid", 64'(out_tvalid), 64'd1);
      chk("bp_tdata", out_tdata, 64'h101);
      chk("bp_src", 64'(out_src), 64'd0);
      chk("bp_dst", 64'(out_dst), 64'h07);
      chk("bp_req_tready", 64'(req_tready), 64'd0);
      chk("bp_grant", 64'(grant_id), 64'd0);
    end
    @(posedge clk);
    #1 tr_val = 1'b1;
    drain("bp", 300);
    chk("bp_hs_total", 64'(hs_cnt[0]), 64'd8);

    // Early release: req1 idles after 2 beats, req3 waits, req1 returns later
    do_reset();
    ord_q = '{1, 1, 3, 3, 3, 3, 1, 1};
    lat_chk = 1'b1;
    cnt_left[1] = 2; cnt_left[3] = 4; en[1] = 1'b1; en[3] = 1'b1;
    c = 0;
    while (hs_cnt[1] < 2 && c < 50) begin @(posedge clk); #1; c++; end
    c = 0;
    do begin @(negedge clk); c++; end while (!req_tready[3] && c < 50);
    chk("early_grant", 64'(grant_id), 64'd3);
    chk("early_busy", 64'(busy), 64'd1);
    @(posedge clk);
    #1 cnt_left[1] = 2;
    drain("early", 300);
    chk("early_order_left", 64'(ord_q.size()), 64'd0);

    // Reset mid-burst while req2 holds the grant and the output register is full
    do_reset();
    seq[2] = 1'b1; seq_nxt[2] = 64'h200; cnt_left[2] = 20; en[2] = 1'b1;
    c = 0;
    do begin @(negedge clk); c++; end while (!(out_tvalid && grant_id == 2'd2) && c < 50);
    chk("mid_pre_grant", 64'(grant_id), 64'd2);
    @(posedge clk);
    #1 arst = 1'b1;
    cnt_left[0] = 2; en[0] = 1'b1;
    @(posedge clk);
    #1 arst = 1'b0;
    clear_sb();
    ord_q = '{0, 0};
    @(negedge clk);
    chk("mid_tvalid", 64'(out_tvalid), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_req_tready", 64'(req_tready), 64'd0);
    @(negedge clk);
    chk("mid_regrant", 64'(grant_id), 64'd0);
    chk("mid_regrant_tready", 64'(req_tready), 64'b0001);
    drain("mid", 400);

    // Randomized traffic with aborts and random output backpressure
    do_reset();
    abort_pct = 5; tr_mode = 1'b1;
    for (int i = 0; i < N; i++) begin
      cnt_left[i] = 25; rate[i] = $urandom_range(30, 90); en[i] = 1'b1;
    end
    drain("rand", 8000);
    chk("rand_leftover", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/lii_tx_arbiter.md
Name: lii_tx_arbiter

Overview:
- Shares one LII physical output channel between N_REQ kernel-wrapper LII output streams.
- Arbitration is round-robin with a bounded burst length per grant, so one wrapper cannot starve the others.
- Sits between the per-layer stream wrappers and the LII phy transmit port.
- Forwards tdata, src and dst unchanged through a single registered output stage.

Parameters:
- N_REQ, 4, number of requesting LII streams (2..16).
- PW, 64, LII packing width.
- MAX_BURST, 4, maximum beats accepted per grant (1..256).

Ports:
- aclk  in  1  clock
- arst  in  1  synchronous reset, active-high
- lii_req_tdata  in  N_REQ*PW  packed requester data; requester i occupies [i*PW +: PW]
- lii_req_tvalid  in  N_REQ  per-requester valid
- lii_req_tready  out  N_REQ  per-requester ready
- lii_req_src  in  N_REQ*8  packed source IDs
- lii_req_dst  in  N_REQ*8  packed destination IDs
- lii_out_p0_tdata  out  PW  phy output data
- lii_out_p0_tvalid  out  1  phy output valid
- lii_out_p0_tready  in  1  phy output ready
- lii_out_p0_src  out  8  forwarded source ID
- lii_out_p0_dst  out  8  forwarded destination ID
- grant_id  out  clog2(N_REQ)  index of the current or last granted requester
- busy  out  1  high while in GRANT or while the output register is full

Behaviour:
- Reset: sync on aclk when arst=1. Clears state→IDLE, rr_ptr=0, grant_id=0, beat_cnt=0, out_full=0. All outputs 0, including out tvalid/tdata/src/dst and lii_req_tready.
- Output stage: one register (data, src, dst, full flag).
  - out tvalid = out_full.
  - load_ok = ~out_full | lii_out_p0_tready.
  - Accepted beat appears on lii_out_p0_* the next cycle (latency 1).
  - Register contents are held stable while tvalid=1 and tready=0.
- IDLE:
  - lii_req_tready all 0.
  - If any tvalid is set, pick the first valid index searching rr_ptr, rr_ptr+1, … (wrapping mod N_REQ).
  - Register that index into grant_id, set beat_cnt=0, go to GRANT.
  - Each new grant therefore costs 1 bubble cycle.
- GRANT (g=grant_id):
  - lii_req_tready[g] = load_ok; all other readies are 0.
  - Beat transfers when lii_req_tvalid[g] & lii_req_tready[g]: load the output register, increment beat_cnt.
  - Release to IDLE, with rr_ptr=(g+1) mod N_REQ, when either:
    - a transfer occurs with beat_cnt==MAX_BURST-1, or
    - lii_req_tvalid[g]==0 in any GRANT cycle (requester idle).
  - Backpressure (load_ok=0) never causes release; the grant is held.
- Output register update: when out_full and lii_out_p0_tready and no new load, clear out_full. A simultaneous drain and load keeps out_full=1 with the new beat.
- Ready timing: lii_req_tready depends combinationally on lii_out_p0_tready (load_ok). A tvalid to tready dependency must not exist.
- Lossless ordering: beats from one requester are emitted in arrival order. No beat is duplicated or dropped.
- Requester tvalid rules: tvalid deasserted without a handshake is tolerated (AXI-S violation by the requester, not by this block). The arbiter simply releases.
- Wrap-around:
  - rr_ptr wraps from N_REQ-1 to 0.
  - beat_cnt width is clog2(MAX_BURST+1) and never exceeds MAX_BURST-1 in GRANT.
- N_REQ=1: degenerates to the same FSM, always granting 0.
- Reset mid-burst: in-flight output beat is discarded and state returns to IDLE. Requesters must re-send.
- busy = (state==GRANT) | out_full.

Test Plan:
- Reset: hold arst=1 for 2 cycles with all tvalid=1 → lii_out_p0_tvalid=0, lii_req_tready=0000, grant_id=0, busy=0.
- Single requester (N_REQ=4, MAX_BURST=4): req2 streams 0x10..0x1B, src=0x02, dst=0x07, out tready=1 → output 0x10..0x1B in order, src/dst preserved, 1-cycle latency, 1-cycle bubble after every 4 beats.
- Fairness: all 4 requesters continuously valid, out tready=1 → grant_id sequence 0,1,2,3,0…, exactly 4 beats each per grant, no beat lost (scoreboard per requester).
- Backpressure: during req0's 2nd beat, hold lii_out_p0_tready=0 for 5 cycles → output tdata/src/dst stable, lii_req_tready[0]=0, grant stays 0. Resuming delivers the remaining beats with no duplicates.
- Early release: req1 drops tvalid after 2 beats while req3 is valid → IDLE, then grant_id=3 (search starts at 2; req2 idle). req1 re-raising later is served after req3.
- Reset mid-burst: assert arst with out_full=1 and grant_id=2 → next cycle lii_out_p0_tvalid=0 and state IDLE. The following grant starts search from rr_ptr=0.
